// File: rtl/slave_ram_responder.sv
// slave_ram_responder
//   Backing memory for an HLS top-level slave memory port. Byte-addressed,
//   little-endian RAM shared by N_CH independent request channels. Every
//   request is accepted on the edge where it is seen (no backpressure).
//   A write acknowledges WRITE_DELAY cycles later. A read returns its data
//   READ_DELAY cycles later. Both completions appear as a one-cycle
//   Sout_DataRdy pulse.
//
// Ports
//   clock            : rising-edge clock
//   reset            : synchronous, active-high; flushes pending responses
//   S_oe_ram[k]      : read strobe, channel k
//   S_we_ram[k]      : write strobe, channel k (takes priority over oe)
//   S_addr_ram       : channel k byte address at [k*ADDR_W +: ADDR_W]
//   S_Wdata_ram      : channel k write data at [k*DATA_W +: DATA_W]
//   S_data_ram_size  : channel k access size in bits at [k*SIZE_W +: SIZE_W]
//   Sout_Rdata_ram   : channel k read data, zero unless a read completes
//   Sout_DataRdy[k]  : one-cycle completion pulse, channel k
module slave_ram_responder #(
    parameter int unsigned N_CH        = 2,
    parameter int unsigned ADDR_W      = 7,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned SIZE_W      = 5,
    parameter int unsigned MEM_BYTES   = 128,
    parameter int unsigned READ_DELAY  = 2,
    parameter int unsigned WRITE_DELAY = 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [N_CH-1:0]          S_oe_ram,
    input  logic [N_CH-1:0]          S_we_ram,
    input  logic [N_CH*ADDR_W-1:0]   S_addr_ram,
    input  logic [N_CH*DATA_W-1:0]   S_Wdata_ram,
    input  logic [N_CH*SIZE_W-1:0]   S_data_ram_size,
    output logic [N_CH*DATA_W-1:0]   Sout_Rdata_ram,
    output logic [N_CH-1:0]          Sout_DataRdy
);

    localparam int unsigned BYTES   = DATA_W / 8;
    localparam int unsigned DEPTH   = (READ_DELAY > WRITE_DELAY) ? READ_DELAY : WRITE_DELAY;
    // A request enters the pipeline at the stage that leaves exactly
    // <delay> edges until it reaches the output stage DEPTH-1.
    localparam int unsigned RD_SLOT = DEPTH - READ_DELAY;
    localparam int unsigned WR_SLOT = DEPTH - WRITE_DELAY;
    localparam int unsigned MEM_AW  = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
    localparam logic [ADDR_W:0] MEM_LIM = (ADDR_W+1)'(MEM_BYTES);

    logic [7:0]        mem_q   [MEM_BYTES];

    logic              ben     [N_CH][BYTES];
    logic [MEM_AW-1:0] bidx    [N_CH][BYTES];
    logic [DATA_W-1:0] rd_cur  [N_CH];

    logic              vld_q   [N_CH][DEPTH];
    logic              vld_d   [N_CH][DEPTH];
    logic              isrd_q  [N_CH][DEPTH];
    logic              isrd_d  [N_CH][DEPTH];
    logic [DATA_W-1:0] dat_q   [N_CH][DEPTH];
    logic [DATA_W-1:0] dat_d   [N_CH][DEPTH];

    // Per-byte enables and addresses. The address is widened by one bit so
    // that addr+i never wraps; anything at or beyond MEM_BYTES is disabled.
    always_comb begin
        logic [SIZE_W:0] sz;
        logic [ADDR_W:0] a;
        logic [ADDR_W:0] ba;
        int unsigned     nb;
        sz = '0;
        a  = '0;
        ba = '0;
        nb = 0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            rd_cur[k] = '0;
            sz = {1'b0, S_data_ram_size[k*SIZE_W +: SIZE_W]} + (SIZE_W+1)'(7);
            nb = 32'(sz >> 3);
            if (nb > BYTES) nb = BYTES;
            a = {1'b0, S_addr_ram[k*ADDR_W +: ADDR_W]};
            for (int unsigned i = 0; i < BYTES; i++) begin
                ba         = a + (ADDR_W+1)'(i);
                ben[k][i]  = (i < nb) && (ba < MEM_LIM);
                bidx[k][i] = ba[MEM_AW-1:0];
                if (ben[k][i]) rd_cur[k][i*8 +: 8] = mem_q[bidx[k][i]];
            end
        end
    end

    // Channels are visited in ascending order so the highest index wins a
    // same-edge byte collision. Reads use mem_q before this edge's update.
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int unsigned k = 0; k < N_CH; k++) begin
                for (int unsigned i = 0; i < BYTES; i++) begin
                    if (S_we_ram[k] && ben[k][i])
                        mem_q[bidx[k][i]] <= S_Wdata_ram[k*DATA_W + i*8 +: 8];
                end
            end
        end
    end

    // Shift pipeline. When a read and a write land in the same stage the
    // entry stays a read and keeps the read data.
    always_comb begin
        for (int unsigned k = 0; k < N_CH; k++) begin
            for (int unsigned s = 0; s < DEPTH; s++) begin
                if (s == 0) begin
                    vld_d[k][s]  = 1'b0;
                    isrd_d[k][s] = 1'b0;
                    dat_d[k][s]  = '0;
                end else begin
                    vld_d[k][s]  = vld_q[k][s-1];
                    isrd_d[k][s] = isrd_q[k][s-1];
                    dat_d[k][s]  = dat_q[k][s-1];
                end
                if (S_we_ram[k] && s == WR_SLOT)
                    vld_d[k][s] = 1'b1;
                if (S_oe_ram[k] && !S_we_ram[k] && s == RD_SLOT) begin
                    vld_d[k][s]  = 1'b1;
                    isrd_d[k][s] = 1'b1;
                    dat_d[k][s]  = rd_cur[k];
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        for (int unsigned k = 0; k < N_CH; k++) begin
            for (int unsigned s = 0; s < DEPTH; s++) begin
                if (reset) begin
                    vld_q[k][s]  <= 1'b0;
                    isrd_q[k][s] <= 1'b0;
                    dat_q[k][s]  <= '0;
                end else begin
                    vld_q[k][s]  <= vld_d[k][s];
                    isrd_q[k][s] <= isrd_d[k][s];
                    dat_q[k][s]  <= dat_d[k][s];
                end
            end
        end
    end

    always_comb begin
        Sout_DataRdy   = '0;
        Sout_Rdata_ram = '0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            Sout_DataRdy[k] = vld_q[k][DEPTH-1];
            if (vld_q[k][DEPTH-1] && isrd_q[k][DEPTH-1])
                Sout_Rdata_ram[k*DATA_W +: DATA_W] = dat_q[k][DEPTH-1];
        end
    end

endmodule

// File: tb/tb_slave_ram_responder.sv
// Directed bench for slave_ram_responder (2 channels, 16-bit data, 8-bit
// address so that addresses beyond the 128-byte RAM can be presented).
module tb_slave_ram_responder;

    logic        clock;
    logic        reset;
    logic [1:0]  oe;
    logic [1:0]  we;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [9:0]  size;
    logic [31:0] rdata;
    logic [1:0]  rdy;
    logic [1:0]  prev_rd;

    int checks = 0;
    int errors = 0;

    slave_ram_responder #(
        .N_CH(2), .ADDR_W(8), .DATA_W(16), .SIZE_W(5),
        .MEM_BYTES(128), .READ_DELAY(2), .WRITE_DELAY(1)
    ) dut (
        .clock(clock),
        .reset(reset),
        .S_oe_ram(oe),
        .S_we_ram(we),
        .S_addr_ram(addr),
        .S_Wdata_ram(wdata),
        .S_data_ram_size(size),
        .Sout_Rdata_ram(rdata),
        .Sout_DataRdy(rdy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // A read one cycle before a write on the same channel would complete
    // together with it (READ_DELAY=2, WRITE_DELAY=1).
    always @(posedge clock) begin
        for (int k = 0; k < 2; k++)
            assert (reset || !(we[k] && prev_rd[k]))
                else $error("FAIL collision ch%0d read/write completions coincide", k);
        prev_rd <= oe & ~we;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input int ch, input logic o, input logic w,
                         input logic [7:0] a, input logic [15:0] d, input logic [4:0] sz);
        oe[ch]             = o;
        we[ch]             = w;
        addr[ch*8 +: 8]    = a;
        wdata[ch*16 +: 16] = d;
        size[ch*5 +: 5]    = sz;
    endtask

    task automatic idle();
        oe = '0;
        we = '0;
    endtask

    task automatic do_write(input string tag, input int ch, input logic [7:0] a,
                            input logic [15:0] d, input logic [4:0] sz);
        drive(ch, 1'b0, 1'b1, a, d, sz);
        step();
        idle();
        chk({tag, "_ack"}, 32'(rdy), 32'(1 << ch));
        chk({tag, "_rdata0"}, rdata, 32'h0);
        step();
        chk({tag, "_ackend"}, 32'(rdy), 32'h0);
    endtask

    task automatic do_read(input string tag, input int ch, input logic [7:0] a,
                           input logic [4:0] sz, input logic [15:0] exp);
        drive(ch, 1'b1, 1'b0, a, 16'h0, sz);
        step();
        idle();
        chk({tag, "_early"}, 32'(rdy), 32'h0);
        step();
        chk({tag, "_rdy"}, 32'(rdy), 32'(1 << ch));
        chk({tag, "_data"}, 32'(rdata[ch*16 +: 16]), 32'(exp));
        step();
        chk({tag, "_rdyend"}, 32'(rdy), 32'h0);
        chk({tag, "_dataend"}, rdata, 32'h0);
    endtask

    initial begin
        oe = '0; we = '0; addr = '0; wdata = '0; size = '0; prev_rd = '0;
        reset = 1'b1;
        step();
        chk("rst_rdy", 32'(rdy), 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        step();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("idle_rdy", 32'(rdy), 32'h0);
            chk("idle_rdata", rdata, 32'h0);
        end

        // basic write / read
        do_write("w10", 0, 8'h10, 16'hBEEF, 5'd16);
        do_read("r10", 0, 8'h10, 5'd16, 16'hBEEF);
        do_read("r11", 0, 8'h11, 5'd8, 16'h00BE);
        do_read("r10clamp", 1, 8'h10, 5'd31, 16'hBEEF);
        do_read("r10sz9", 1, 8'h10, 5'd9, 16'hBEEF);

        // back-to-back reads on channel 1
        do_write("w12", 0, 8'h12, 16'hFF77, 5'd8);
        drive(1, 1'b1, 1'b0, 8'h10, 16'h0, 5'd8);
        step();
        chk("b2b_r0_early", 32'(rdy), 32'h0);
        drive(1, 1'b1, 1'b0, 8'h11, 16'h0, 5'd8);
        step();
        chk("b2b_r0_rdy", 32'(rdy), 32'h2);
        chk("b2b_r0_data", rdata, 32'h00EF_0000);
        drive(1, 1'b1, 1'b0, 8'h12, 16'h0, 5'd8);
        step();
        idle();
        chk("b2b_r1_rdy", 32'(rdy), 32'h2);
        chk("b2b_r1_data", rdata, 32'h00BE_0000);
        step();
        chk("b2b_r2_rdy", 32'(rdy), 32'h2);
        chk("b2b_r2_data", rdata, 32'h0077_0000);
        step();
        chk("b2b_end", 32'(rdy), 32'h0);

        // same-edge write collision: channel 1 wins
        drive(0, 1'b0, 1'b1, 8'h20, 16'h0012, 5'd8);
        drive(1, 1'b0, 1'b1, 8'h20, 16'h0034, 5'd8);
        step();
        idle();
        chk("coll_ack", 32'(rdy), 32'h3);
        step();
        do_read("coll_rd", 0, 8'h20, 5'd8, 16'h0034);

        // read-before-write on the same edge
        do_write("w30", 0, 8'h30, 16'h0055, 5'd8);
        drive(0, 1'b1, 1'b0, 8'h30, 16'h0, 5'd8);
        drive(1, 1'b0, 1'b1, 8'h30, 16'h0066, 5'd8);
        step();
        idle();
        chk("rbw_wack", 32'(rdy), 32'h2);
        step();
        chk("rbw_rrdy", 32'(rdy), 32'h1);
        chk("rbw_old", rdata, 32'h0000_0055);
        step();
        do_read("rbw_new", 0, 8'h30, 5'd8, 16'h0066);

        // top of memory and out-of-range addresses
        do_write("w7f", 0, 8'h7F, 16'hAAAA, 5'd16);
        do_read("r7f", 1, 8'h7F, 5'd16, 16'h00AA);
        do_read("r90", 0, 8'h90, 5'd16, 16'h0000);

        // size 0 and oe=we=1
        do_write("w40", 0, 8'h40, 16'h0011, 5'd8);
        do_write("w40sz0", 1, 8'h40, 16'hFFFF, 5'd0);
        do_read("r40keep", 0, 8'h40, 5'd8, 16'h0011);
        do_read("r40sz0", 1, 8'h40, 5'd0, 16'h0000);
        drive(0, 1'b1, 1'b1, 8'h40, 16'h005A, 5'd8);
        step();
        idle();
        chk("oewe_ack", 32'(rdy), 32'h1);
        chk("oewe_rdata", rdata, 32'h0);
        step();
        chk("oewe_noread", 32'(rdy), 32'h0);
        step();
        chk("oewe_noread2", 32'(rdy), 32'h0);
        do_read("r40new", 1, 8'h40, 5'd8, 16'h005A);

        // reset while a read is in flight
        drive(0, 1'b1, 1'b0, 8'h10, 16'h0, 5'd16);
        step();
        idle();
        reset = 1'b1;
        step();
        chk("rstmid_rdy", 32'(rdy), 32'h0);
        chk("rstmid_rdata", rdata, 32'h0);
        reset = 1'b0;
        step();
        chk("rstmid_late", 32'(rdy), 32'h0);
        step();
        chk("rstmid_late2", 32'(rdy), 32'h0);
        do_read("rstmid_keep", 0, 8'h10, 5'd16, 16'hBEEF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
